button_conditioner: RTL and testbench
=====================================

# button_conditioner

Front-end stage for the combination lock FSM. Two-flop synchronises the two raw push-buttons (confirm, Change) and the four code switches (x3..x0), debounces the buttons, and emits exactly one single-cycle pulse per debounced press. Its outputs drive the lock FSM's `confirmpulse`, `changepulse` and code inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required before a button's debounced state changes; legal range 1..65535.
- `Clock`  in  1  single system clock, all logic on posedge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `confirm`  in  1  raw confirm button, active-low (0 = pressed), asynchronous.
- `Change`  in  1  raw change button, active-low, asynchronous.
- `x3, x2, x1, x0`  in  1 each  raw code switches, asynchronous.
- `confirmpulse`  out  1  one-cycle pulse per debounced confirm press.
- `changepulse`  out  1  one-cycle pulse per debounced Change press.
- `code`  out  4  code presented to the lock FSM, `{x3,x2,x1,x0}` order.
- `confirm_held`, `change_held`  out  1 each  debounced pressed level, 1 = pressed.

## Operation
- Reset (async assert, sync release): sync flops for buttons = 1 (released); switch sync flops = 0; debounce counters = 0; debounced states = released; all outputs 0, `code` = 4'b0000.
- Synchroniser: every raw input passes through two flops; only the second-stage value (`s2`) is used.
- Debounce per button: if `s2` equals the debounced state, the counter clears to 0. Otherwise the counter increments. When the counter would reach `DEBOUNCE_CYCLES`, the debounced state takes `s2` and the counter clears. Any agreeing sample before that point restarts the count.
- Counter width: `$clog2(DEBOUNCE_CYCLES+1)`. The counter saturates and never wraps.
- Pulse: registered and asserted for exactly one cycle on the debounced released-to-pressed transition. Release and hold produce no pulse, so there is no auto-repeat.
- Simultaneous qualification: if both buttons qualify on the same edge, only `confirmpulse` fires. The Change press is consumed: `changepulse` stays 0 and there is no later pulse for that press. `change_held` still goes 1.
- `confirm_held` / `change_held` are the debounced states, registered.

## Timing
- Raw press stable from before edge k: `s2` = pressed after edge k+1.
- Debounced state changes at edge k+1+`DEBOUNCE_CYCLES`.
- Pulse is high for the single cycle after edge k+2+`DEBOUNCE_CYCLES`. Press-to-pulse latency is `DEBOUNCE_CYCLES`+3 edges.
- Release follows the same latency for the `*_held` outputs.
- Minimum gap between two pulses of one button: 2·`DEBOUNCE_CYCLES` cycles (release plus re-press).
- Reset mid-count: the count is lost. A press held through reset release is re-debounced and produces one pulse `DEBOUNCE_CYCLES`+3 edges after the buttons' sync flops first sample pressed.

## Configuration
- `CODE_SNAPSHOT_EN` defined:
  - `code` is a register loaded from the synchronised switches only on the edge where either pulse asserts.
  - The loaded value is therefore valid in the same cycle as the pulse and held until the next pulse.
  - The value is 0 after reset.
- Not defined:
  - `code` = synchronised switches continuously, 2-cycle latency, with no relation to pulses.

## Structure
- Shared package `combolock_pkg`:
  - `BTN_PRESSED = 1'b0`
  - `DEBOUNCE_DEFAULT = 16`
  - `code_t` = `logic [3:0]`, reused by the lock FSM.
- One sub-module, `debounce_ch`: synchroniser, counter and debounced state for one button, instantiated twice.
- Pulse generation, priority and code capture stay in the top module.

## Test plan
- Reset with both buttons released, then hold `confirm`=0 for 40 cycles (`DEBOUNCE_CYCLES`=16) -> `confirmpulse` high for exactly one cycle, 19 edges after the first sampling edge; `confirm_held`=1 until release +18.
- Bounce: `Change` toggles every 3 cycles for 30 cycles, then holds 0 -> no pulse during bounce; a single `changepulse` 19 edges after the final stable 0.
- Simultaneous: both buttons go to 0 on the same cycle and are held -> one `confirmpulse`, zero `changepulse`, both `*_held`=1.
- `CODE_SNAPSHOT_EN`: switches = 4'b0110, press confirm; change switches to 4'b1111 while held -> `code`=4'b0110 from the pulse cycle until the next press.
- Without the macro: switches change 4'b0000 -> 4'b1010 -> `code`=4'b1010 exactly 2 edges later.
- Drop `Resetn` 10 cycles into a held press, release it and keep holding -> all outputs 0 during reset; one pulse 19 edges after release.

Source files
------------

// File: rtl/combolock_pkg.sv
// Types and constants shared by the combination lock front end and the lock FSM.
package combolock_pkg;

   localparam logic BTN_PRESSED      = 1'b0;
   localparam int   DEBOUNCE_DEFAULT = 16;

   typedef logic [3:0] code_t;

endpackage

// File: rtl/button_conditioner_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter and debounced state.
module debounce_ch
   import combolock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic btn_i,
   output logic pressed_o
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Any sample agreeing with the debounced state restarts the count; the
   // count never passes CNT_LAST, so it cannot wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (s2_q != state_q) begin
         if (cnt_q >= CNT_LAST) begin
            state_d = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_q    <= ~BTN_PRESSED;
         s2_q    <= ~BTN_PRESSED;
         state_q <= ~BTN_PRESSED;
         cnt_q   <= '0;
      end else begin
         s1_q    <= btn_i;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pressed_o = (state_q == BTN_PRESSED);

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces confirm/Change, emits one pulse per press, presents the code.
// Define CODE_SNAPSHOT_EN to latch the code only when a pulse fires.
module button_conditioner
   import combolock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic  Clock,
   input  logic  Resetn,
   input  logic  confirm,
   input  logic  Change,
   input  logic  x3,
   input  logic  x2,
   input  logic  x1,
   input  logic  x0,
   output logic  confirmpulse,
   output logic  changepulse,
   output code_t code,
   output logic  confirm_held,
   output logic  change_held
);

   code_t sw_s1_q, sw_s2_q;
   logic  cf_held, ch_held;
   logic  cf_prev_q, ch_prev_q;
   logic  cf_pulse_q, cf_pulse_d;
   logic  ch_pulse_q, ch_pulse_d;

   debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
      .clk_i     (Clock),
      .rst_n_i   (Resetn),
      .btn_i     (confirm),
      .pressed_o (cf_held)
   );

   debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_change (
      .clk_i     (Clock),
      .rst_n_i   (Resetn),
      .btn_i     (Change),
      .pressed_o (ch_held)
   );

   // Confirm wins a same-edge tie; the Change press is swallowed for good
   // because its rising edge is only seen once.
   always_comb begin
      cf_pulse_d = cf_held & ~cf_prev_q;
      ch_pulse_d = ch_held & ~ch_prev_q & ~cf_pulse_d;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         cf_prev_q  <= 1'b0;
         ch_prev_q  <= 1'b0;
         cf_pulse_q <= 1'b0;
         ch_pulse_q <= 1'b0;
      end else begin
         sw_s1_q    <= {x3, x2, x1, x0};
         sw_s2_q    <= sw_s1_q;
         cf_prev_q  <= cf_held;
         ch_prev_q  <= ch_held;
         cf_pulse_q <= cf_pulse_d;
         ch_pulse_q <= ch_pulse_d;
      end
   end

`ifdef CODE_SNAPSHOT_EN
   code_t code_q, code_d;

   // Loaded on the same edge the pulse register rises, so code is valid with the pulse.
   always_comb begin
      code_d = code_q;
      if (cf_pulse_d || ch_pulse_d) code_d = sw_s2_q;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) code_q <= '0;
      else         code_q <= code_d;
   end

   assign code = code_q;
`else
   assign code = sw_s2_q;
`endif

   assign confirmpulse = cf_pulse_q;
   assign changepulse  = ch_pulse_q;
   assign confirm_held = cf_held;
   assign change_held  = ch_held;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: expected pulse cycles queued at stimulus time, matched against observed pulses.
module tb_button_conditioner;
   import combolock_pkg::*;

   localparam int D = 16;

   logic  Clock = 1'b0, Resetn = 1'b0;
   logic  confirm = 1'b1, Change = 1'b1;
   logic  x3 = 1'b0, x2 = 1'b0, x1 = 1'b0, x0 = 1'b0;
   logic  confirmpulse, changepulse, confirm_held, change_held;
   code_t code;

   int cyc = 0;
   int errors = 0, checks = 0;
   int exp_q[$], obs_q[$];

   button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .Clock(Clock), .Resetn(Resetn), .confirm(confirm), .Change(Change),
      .x3(x3), .x2(x2), .x1(x1), .x0(x0),
      .confirmpulse(confirmpulse), .changepulse(changepulse), .code(code),
      .confirm_held(confirm_held), .change_held(change_held)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // Pulse log: entry = cycle*2 + channel (0 confirm, 1 change).
   always @(negedge Clock) begin
      if (confirmpulse) obs_q.push_back(cyc * 2);
      if (changepulse)  obs_q.push_back(cyc * 2 + 1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic test_reset();
      wait_cyc(3);
      checks++;
      if ({confirmpulse, changepulse, confirm_held, change_held} !== 4'b0000) begin
         errors++; $display("FAIL reset_outs: got %b, required 0000", {confirmpulse, changepulse, confirm_held, change_held});
      end
      checks++;
      if (code !== 4'b0000) begin errors++; $display("FAIL reset_code: got %b, required 0000", code); end
      Resetn = 1'b1;
      wait_cyc(5);
      checks++;
      if ({confirm_held, change_held} !== 2'b00) begin
         errors++; $display("FAIL post_reset_held: got %b, required 00", {confirm_held, change_held});
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL post_reset_pulse: got %0d pulses, required 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_confirm_press();
      int c, r, e, o;
      @(negedge Clock); confirm = 1'b0; c = cyc;
      exp_q.push_back((c + D + 3) * 2);
      wait_cyc(D + 1);
      checks++;
      if (confirm_held !== 1'b0) begin errors++; $display("FAIL cf_held_early: got %b, required 0", confirm_held); end
      wait_cyc(1);
      checks++;
      if (confirm_held !== 1'b1) begin errors++; $display("FAIL cf_held_set: got %b, required 1", confirm_held); end
      wait_cyc(40 - (D + 2));
      confirm = 1'b1; r = cyc;
      wait_cyc(D + 1);
      checks++;
      if (confirm_held !== 1'b1) begin errors++; $display("FAIL cf_held_release_early: got %b, required 1", confirm_held); end
      wait_cyc(1);
      checks++;
      if (confirm_held !== 1'b0) begin errors++; $display("FAIL cf_held_release: got %b, required 0", confirm_held); end
      wait_cyc(5);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL confirm_pulse: missing, required cyc=%0d ch=%0d", e / 2, e % 2); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL confirm_pulse: got cyc=%0d ch=%0d, required cyc=%0d ch=%0d", o / 2, o % 2, e / 2, e % 2); end
         end
      end
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); checks++; errors++;
         $display("FAIL confirm_extra: got pulse cyc=%0d ch=%0d, required none", o / 2, o % 2);
      end
   endtask

   task automatic test_bounce();
      int c, e, o;
      for (int i = 0; i < 10; i++) begin
         Change = (i % 2 == 0) ? 1'b0 : 1'b1;
         wait_cyc(3);
      end
      checks++;
      if (obs_q.size() != 0 || change_held !== 1'b0) begin
         errors++; $display("FAIL bounce_quiet: got pulses=%0d held=%b, required 0/0", obs_q.size(), change_held);
      end
      Change = 1'b0; c = cyc;
      exp_q.push_back((c + D + 3) * 2 + 1);
      wait_cyc(D + 6);
      checks++;
      if (change_held !== 1'b1) begin errors++; $display("FAIL ch_held: got %b, required 1", change_held); end
      Change = 1'b1;
      wait_cyc(D + 6);
      checks++;
      if (change_held !== 1'b0) begin errors++; $display("FAIL ch_release: got %b, required 0", change_held); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL bounce_pulse: missing, required cyc=%0d ch=%0d", e / 2, e % 2); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL bounce_pulse: got cyc=%0d ch=%0d, required cyc=%0d ch=%0d", o / 2, o % 2, e / 2, e % 2); end
         end
      end
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); checks++; errors++;
         $display("FAIL bounce_extra: got pulse cyc=%0d ch=%0d, required none", o / 2, o % 2);
      end
   endtask

   task automatic test_simultaneous();
      int c, e, o;
      @(negedge Clock); confirm = 1'b0; Change = 1'b0; c = cyc;
      exp_q.push_back((c + D + 3) * 2);
      wait_cyc(D + 6);
      checks++;
      if ({confirm_held, change_held} !== 2'b11) begin
         errors++; $display("FAIL simul_held: got %b, required 11", {confirm_held, change_held});
      end
      confirm = 1'b1; Change = 1'b1;
      wait_cyc(D + 6);
      checks++;
      if ({confirm_held, change_held} !== 2'b00) begin
         errors++; $display("FAIL simul_release: got %b, required 00", {confirm_held, change_held});
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL simul_pulse: missing, required cyc=%0d ch=%0d", e / 2, e % 2); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL simul_pulse: got cyc=%0d ch=%0d, required cyc=%0d ch=%0d", o / 2, o % 2, e / 2, e % 2); end
         end
      end
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); checks++; errors++;
         $display("FAIL simul_extra: got pulse cyc=%0d ch=%0d, required none", o / 2, o % 2);
      end
   endtask

   task automatic test_code();
      int c, e, o;
`ifdef CODE_SNAPSHOT_EN
      {x3, x2, x1, x0} = 4'b0110;
      wait_cyc(3);
      confirm = 1'b0; c = cyc;
      exp_q.push_back((c + D + 3) * 2);
      wait_cyc(D + 2);
      checks++;
      if (code !== 4'b0000) begin errors++; $display("FAIL snap_before: got %b, required 0000", code); end
      wait_cyc(1);
      checks++;
      if (code !== 4'b0110) begin errors++; $display("FAIL snap_load: got %b, required 0110", code); end
      {x3, x2, x1, x0} = 4'b1111;
      wait_cyc(10);
      checks++;
      if (code !== 4'b0110) begin errors++; $display("FAIL snap_hold: got %b, required 0110", code); end
      confirm = 1'b1;
      wait_cyc(D + 6);
      checks++;
      if (code !== 4'b0110) begin errors++; $display("FAIL snap_release: got %b, required 0110", code); end
      confirm = 1'b0; c = cyc;
      exp_q.push_back((c + D + 3) * 2);
      wait_cyc(D + 3);
      checks++;
      if (code !== 4'b1111) begin errors++; $display("FAIL snap_reload: got %b, required 1111", code); end
      confirm = 1'b1;
      wait_cyc(D + 6);
`else
      @(negedge Clock); {x3, x2, x1, x0} = 4'b1010; c = cyc;
      wait_cyc(1);
      checks++;
      if (code !== 4'b0000) begin errors++; $display("FAIL code_lat1: got %b, required 0000", code); end
      wait_cyc(1);
      checks++;
      if (code !== 4'b1010) begin errors++; $display("FAIL code_lat2: got %b, required 1010", code); end
      wait_cyc(3);
`endif
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL code_pulse: missing, required cyc=%0d ch=%0d", e / 2, e % 2); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL code_pulse: got cyc=%0d ch=%0d, required cyc=%0d ch=%0d", o / 2, o % 2, e / 2, e % 2); end
         end
      end
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); checks++; errors++;
         $display("FAIL code_extra: got pulse cyc=%0d ch=%0d, required none", o / 2, o % 2);
      end
   endtask

   task automatic test_reset_mid_press();
      int rc, e, o;
      @(negedge Clock); confirm = 1'b0;
      wait_cyc(10);
      Resetn = 1'b0;
      wait_cyc(1);
      checks++;
      if ({confirmpulse, changepulse, confirm_held, change_held} !== 4'b0000 || code !== 4'b0000) begin
         errors++; $display("FAIL midrst_outs: got %b code=%b, required 0000 code=0000",
                            {confirmpulse, changepulse, confirm_held, change_held}, code);
      end
      wait_cyc(3);
      Resetn = 1'b1; rc = cyc;
      exp_q.push_back((rc + D + 3) * 2);
      wait_cyc(D + 6);
      checks++;
      if (confirm_held !== 1'b1) begin errors++; $display("FAIL midrst_held: got %b, required 1", confirm_held); end
      confirm = 1'b1;
      wait_cyc(D + 6);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL midrst_pulse: missing, required cyc=%0d ch=%0d", e / 2, e % 2); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin errors++; $display("FAIL midrst_pulse: got cyc=%0d ch=%0d, required cyc=%0d ch=%0d", o / 2, o % 2, e / 2, e % 2); end
         end
      end
      while (obs_q.size() != 0) begin
         o = obs_q.pop_front(); checks++; errors++;
         $display("FAIL midrst_extra: got pulse cyc=%0d ch=%0d, required none", o / 2, o % 2);
      end
   endtask

   initial begin
      test_reset();
      test_confirm_press();
      test_bounce();
      test_simultaneous();
      test_code();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
